// File: rtl/xt_bus_pkg.sv
// Shared definitions for the XT-style read bus and the boot-time ROM shadow copier.
// Holds bus widths, the default BIOS window and the rom_shadow state encoding.
package xt_bus_pkg;

  localparam int              ADDR_W    = 20;
  localparam logic [19:0]     BIOS_BASE = 20'hFE000;
  localparam int              BIOS_LEN  = 8192;

  typedef enum logic [2:0] {
    ST_READ  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } shadow_state_e;

  // Modulo-256 running image sum; a good image sums to zero.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/rom_shadow.sv
// Boot-time initiator that copies a ROM image into shadow RAM and holds the CPU until done.
// Optional image checksum check is enabled by defining ROM_SHADOW_CHECKSUM_EN.
module rom_shadow
  import xt_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_BASE = BIOS_BASE,
  parameter logic [ADDR_W-1:0] DST_BASE = BIOS_BASE,
  parameter int                LEN      = BIOS_LEN
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oRd,
  input  logic              iSel,
  input  logic [7:0]        iData,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [7:0]        oWrData,
  output logic              oWr,
  input  logic              iWrReady,
  output logic              oHold,
  output logic              oDone,
  output logic              oErr
);

  localparam logic [16:0] LAST_IDX = 17'(LEN - 1);

  shadow_state_e state_r;
  logic [16:0]   count_r;
  logic [19:0]   count_ext;

`ifdef ROM_SHADOW_CHECKSUM_EN
  logic [7:0]    sum_r;
`endif

  // Count is 17 bits; addresses wrap modulo 2^20.
  assign count_ext = {3'b000, count_r};

  // Copy sequencer: one outstanding read, then a held write per byte.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r <= ST_READ;
      count_r <= 17'd0;
      oRd     <= 1'b0;
      oWr     <= 1'b0;
      oAddr   <= 20'h00000;
      oWrAddr <= 20'h00000;
      oWrData <= 8'h00;
      oDone   <= 1'b0;
      oErr    <= 1'b0;
      oHold   <= 1'b1;
`ifdef ROM_SHADOW_CHECKSUM_EN
      sum_r   <= 8'h00;
`endif
    end else begin
      case (state_r)
        ST_READ: begin
          oRd     <= 1'b1;
          oAddr   <= SRC_BASE + count_ext;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          oRd <= 1'b0;
          if (iSel) begin
            oWrData <= iData;
            oWrAddr <= DST_BASE + count_ext;
            oWr     <= 1'b1;
`ifdef ROM_SHADOW_CHECKSUM_EN
            sum_r   <= csum_add(sum_r, iData);
`endif
            state_r <= ST_WRITE;
          end else begin
            oErr    <= 1'b1;
            state_r <= ST_ERR;
          end
        end
        ST_WRITE: begin
          if (iWrReady) begin
            oWr     <= 1'b0;
            count_r <= count_r + 17'd1;
            if (count_r == LAST_IDX) begin
`ifdef ROM_SHADOW_CHECKSUM_EN
              if (sum_r != 8'h00) begin
                oErr    <= 1'b1;
                state_r <= ST_ERR;
              end else begin
                oDone   <= 1'b1;
                oHold   <= 1'b0;
                state_r <= ST_DONE;
              end
`else
              oDone   <= 1'b1;
              oHold   <= 1'b0;
              state_r <= ST_DONE;
`endif
            end else begin
              state_r <= ST_READ;
            end
          end else begin
            oWr <= 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          oRd <= 1'b0;
          oWr <= 1'b0;
          if (iStart) begin
            oDone   <= 1'b0;
            oErr    <= 1'b0;
            oHold   <= 1'b1;
            count_r <= 17'd0;
`ifdef ROM_SHADOW_CHECKSUM_EN
            sum_r   <= 8'h00;
`endif
            state_r <= ST_READ;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          oRd     <= 1'b0;
          oWr     <= 1'b0;
          oErr    <= 1'b1;
          oHold   <= 1'b1;
          state_r <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_shadow.sv
// Directed bench for rom_shadow: nominal copy, back-pressure, missing responder,
// mid-copy reset, image checksum and source address wrap (LEN=4, SRC_BASE=FFFFE).
module tb_rom_shadow;
  import xt_bus_pkg::*;

  localparam logic [19:0] SRC = 20'hFFFFE;
  localparam logic [19:0] DST = 20'hFE000;
  localparam int          LEN = 4;

  logic        iClk, iRst, iStart, iSel, iWrReady;
  logic [7:0]  iData;
  logic [19:0] oAddr, oWrAddr;
  logic [7:0]  oWrData;
  logic        oRd, oWr, oHold, oDone, oErr;

  int vecs = 0;
  int miscompares = 0;

  logic [7:0]  rom [4];
  logic        miss_en = 1'b0;
  logic [19:0] miss_idx = 20'd0;
  logic [19:0] stall_addr = 20'h00000;
  int          stall_len = 0;

  logic [27:0] wr_log [$];
  logic [19:0] rd_log [$];
  int          excl_viol = 0;
  int          stable_viol = 0;
  int          wr_age = 0;
  logic        prev_wr = 1'b0;
  logic [27:0] prev_wr_word = 28'h0;
  logic [19:0] idx;

  rom_shadow #(.SRC_BASE(SRC), .DST_BASE(DST), .LEN(LEN)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
    .oAddr(oAddr), .oRd(oRd), .iSel(iSel), .iData(iData),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oWr(oWr), .iWrReady(iWrReady),
    .oHold(oHold), .oDone(oDone), .oErr(oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Responder, RAM ready model and bus monitor, evaluated mid-cycle.
  always @(negedge iClk) begin
    idx      = oAddr - SRC;
    iSel     = oRd && !(miss_en && idx == miss_idx);
    iData    = iSel ? rom[idx[1:0]] : 8'h00;
    iWrReady = !(oWr && oWrAddr == stall_addr && wr_age < stall_len);
    if (oWr && iWrReady) wr_log.push_back({oWrAddr, oWrData});
    if (oRd) rd_log.push_back(oAddr);
    if (oRd && oWr) excl_viol++;
    if (oWr && prev_wr && ({oWrAddr, oWrData} != prev_wr_word)) stable_viol++;
    prev_wr      = oWr;
    prev_wr_word = {oWrAddr, oWrData};
    wr_age       = oWr ? wr_age + 1 : 0;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge iClk);
    #1;
  endtask

  task automatic wait_end(inout int cyc);
    while (!(oDone || oErr) && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic start_run(output int cyc);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    cyc = 1;
    wait_end(cyc);
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    check_vec({tag, "_wr_count"}, 32'(wr_log.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (wr_log.size() > base + i)
        check_vec($sformatf("%s_wr%0d", tag, i), {4'h0, wr_log[base + i]},
                  {4'h0, DST + 20'(i), rom[i]});
    end
  endtask

  task automatic check_reads(input string tag, input int base);
    logic [19:0] exp_a;
    check_vec({tag, "_rd_count"}, 32'(rd_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_a = SRC + 20'(i);
      if (rd_log.size() > base + i)
        check_vec($sformatf("%s_rd%0d", tag, i), {12'h0, rd_log[base + i]}, {12'h0, exp_a});
    end
  endtask

  initial begin
    int cyc;
    int wb, rb, ex0, st0;
    bit found;

    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h9A;
    iRst = 1'b1;
    iStart = 1'b0;
    repeat (3) tick();

    check_vec("rst_outputs", {oRd, oWr, oDone, oErr, oHold}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    check_vec("rst_addr", {12'h0, oAddr}, 32'h0);
    check_vec("rst_wraddr_data", {4'h0, oWrAddr, oWrData}, 32'h0);

    // Nominal copy from reset release, with source address wrap.
    wb = wr_log.size(); rb = rd_log.size();
    iRst = 1'b0;
    cyc = 0;
    wait_end(cyc);
    check_vec("nom_cycles", 32'(cyc), 32'd12);
    check_vec("nom_flags", {oDone, oHold, oErr}, {1'b1, 1'b0, 1'b0});
    check_writes("nom", wb, 4);
    check_reads("wrap", rb);

    // Five cycles of back-pressure on byte 1.
    wb = wr_log.size(); ex0 = excl_viol; st0 = stable_viol;
    stall_addr = DST + 20'd1; stall_len = 5;
    start_run(cyc);
    check_vec("bp_cycles", 32'(cyc), 32'd18);
    check_vec("bp_done", {oDone, oHold, oErr}, {1'b1, 1'b0, 1'b0});
    check_writes("bp", wb, 4);
    check_vec("bp_rd_during_wr", 32'(excl_viol - ex0), 32'd0);
    check_vec("bp_wr_stable", 32'(stable_viol - st0), 32'd0);
    stall_len = 0;

    // Responder absent on byte 2.
    wb = wr_log.size();
    miss_en = 1'b1; miss_idx = 20'd2;
    start_run(cyc);
    check_vec("miss_cycles", 32'(cyc), 32'd9);
    check_vec("miss_flags", {oDone, oHold, oErr}, {1'b0, 1'b1, 1'b1});
    check_writes("miss", wb, 2);
    repeat (3) tick();
    check_vec("miss_stays_err", {oErr, oHold, oRd, oWr}, {1'b1, 1'b1, 1'b0, 1'b0});

    // Restart from ERR reruns the whole copy.
    miss_en = 1'b0;
    wb = wr_log.size(); rb = rd_log.size();
    start_run(cyc);
    check_vec("rerun_cycles", 32'(cyc), 32'd13);
    check_vec("rerun_flags", {oDone, oHold, oErr}, {1'b1, 1'b0, 1'b0});
    check_writes("rerun", wb, 4);
    check_reads("rerun", rb);

    // Reset while the write of byte 3 is held off.
    stall_addr = DST + 20'd3; stall_len = 1000;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (oWr && oWrAddr == DST + 20'd3) found = 1'b1;
      else tick();
    end
    check_vec("mid_reached_wr3", {31'h0, found}, 32'd1);
    iRst = 1'b1;
    tick();
    check_vec("mid_rst_outputs", {oRd, oWr, oDone, oErr, oHold}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    stall_len = 0;
    wb = wr_log.size(); rb = rd_log.size();
    iRst = 1'b0;
    cyc = 0;
    wait_end(cyc);
    check_vec("mid_cycles", 32'(cyc), 32'd12);
    check_reads("mid", rb);
    check_writes("mid", wb, 4);

    // Bad image: last byte off by one.
    rom[3] = 8'h9B;
    wb = wr_log.size();
    start_run(cyc);
    check_vec("csum_cycles", 32'(cyc), 32'd13);
`ifdef ROM_SHADOW_CHECKSUM_EN
    check_vec("csum_bad_flags", {oDone, oHold, oErr}, {1'b0, 1'b1, 1'b1});
`else
    check_vec("csum_bad_flags", {oDone, oHold, oErr}, {1'b1, 1'b0, 1'b0});
`endif
    check_writes("csum", wb, 4);

    // Good image again after restart.
    rom[3] = 8'h9A;
    start_run(cyc);
    check_vec("csum_good_flags", {oDone, oHold, oErr}, {1'b1, 1'b0, 1'b0});
    check_vec("all_rd_wr_excl", 32'(excl_viol), 32'd0);
    check_vec("all_wr_stable", 32'(stable_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
